pc_sequencer: RTL and testbench

//  Control sequencer for the fetch-stage PC register. Arbitrates next-PC requests (branch/jump

---
 rtl/cpu_pkg.sv | 7 +
 rtl/pc_sequencer_if.sv | 26 ++
 rtl/pc_redirect_arb.sv | 20 ++
 rtl/pc_sequencer.sv | 83 ++++++++
 tb/tb_pc_sequencer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared PC-select codes, sequencer states and arbitration winners
package cpu_pkg;
  localparam logic [15:0] EXC_VECTOR_DEF = 16'h0002;
  typedef enum logic [1:0] {PCS_INC = 2'b00, PCS_HOLD = 2'b01, PCS_TGT = 2'b10, PCS_VEC = 2'b11} pc_sel_t;
  typedef enum logic [1:0] {SEQ_RUN, SEQ_WAIT, SEQ_HALT} seq_state_t;
  typedef enum logic [2:0] {WIN_NONE, WIN_SIIC, WIN_HALT, WIN_RTI, WIN_REDIR, WIN_STALL} win_t;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: request and PC-control signals between control logic and the sequencer
interface pc_sequencer_if import cpu_pkg::*; #(parameter int AW = 16);
  logic redir_req;
  logic [AW-1:0] redir_tgt;
  logic siic_req;
  logic [AW-1:0] siic_pc;
  logic rti_req;
  logic halt_req;
  logic hazard_stall;
  logic imem_ready;
  pc_sel_t pc_sel;
  logic [AW-1:0] pc_tgt;
  logic flush_ifid;
  logic flush_idex;
  logic [AW-1:0] epc;
  logic in_handler;
  logic halted;
  modport master (
    output redir_req, redir_tgt, siic_req, siic_pc, rti_req, halt_req, hazard_stall, imem_ready,
    input pc_sel, pc_tgt, flush_ifid, flush_idex, epc, in_handler, halted
  );
  modport slave (
    input redir_req, redir_tgt, siic_req, siic_pc, rti_req, halt_req, hazard_stall, imem_ready,
    output pc_sel, pc_tgt, flush_ifid, flush_idex, epc, in_handler, halted
  );
endinterface

// File: rtl/pc_redirect_arb.sv
// pc_redirect_arb: fixed-priority pick among next-PC requests plus the winner's target
module pc_redirect_arb import cpu_pkg::*; #(
  parameter int AW = 16,
  parameter logic [AW-1:0] EXC_VEC = AW'(EXC_VECTOR_DEF)
) (
  input  logic siic,
  input  logic halt,
  input  logic rti,
  input  logic redir,
  input  logic stall,
  input  logic [AW-1:0] redir_tgt,
  input  logic [AW-1:0] epc,
  output win_t win,
  output logic [AW-1:0] tgt
);
  always_comb begin
    win = siic ? WIN_SIIC : halt ? WIN_HALT : rti ? WIN_RTI : redir ? WIN_REDIR : stall ? WIN_STALL : WIN_NONE;
    tgt = siic ? EXC_VEC : halt ? '0 : rti ? epc : redir ? redir_tgt : '0;
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: arbitrates next-PC requests into a select code and target, owns EPC and flushes
module pc_sequencer import cpu_pkg::*; #(
  parameter int AW = 16,
  parameter logic [AW-1:0] EXC_VECTOR = AW'(EXC_VECTOR_DEF)
) (
  input logic clk,
  input logic rst_n,
  pc_sequencer_if.slave bus
);
  seq_state_t state, nstate;
  win_t win;
  pc_sel_t sel;
  logic [AW-1:0] arb_tgt, tgt, pend_tgt, epc;
  logic pend_vec, vec, fl_ifid, fl_idex, in_handler, load_pend, take_exc, take_rti;
  pc_redirect_arb #(.AW(AW), .EXC_VEC(EXC_VECTOR)) u_arb (
    .siic(bus.siic_req), .halt(bus.halt_req), .rti(bus.rti_req), .redir(bus.redir_req),
    .stall(bus.hazard_stall), .redir_tgt(bus.redir_tgt), .epc(epc), .win(win), .tgt(arb_tgt)
  );
  always_comb begin
    nstate = state;
    sel = PCS_HOLD;
    tgt = '0;
    fl_ifid = 1'b0;
    fl_idex = 1'b0;
    vec = 1'b0;
    load_pend = 1'b0;
    take_exc = 1'b0;
    take_rti = 1'b0;
    case (state)
      SEQ_RUN: begin
        if (win == WIN_SIIC && in_handler) nstate = SEQ_HALT;
        else if (win == WIN_HALT) begin
          nstate = SEQ_HALT;
          fl_ifid = 1'b1;
          fl_idex = 1'b1;
        end else if (win inside {WIN_SIIC, WIN_RTI, WIN_REDIR}) begin
          fl_ifid = 1'b1;
          fl_idex = 1'b1;
          vec = win == WIN_SIIC;
          take_exc = vec;
          take_rti = win == WIN_RTI;
          sel = bus.imem_ready ? (vec ? PCS_VEC : PCS_TGT) : PCS_HOLD;
          tgt = bus.imem_ready ? arb_tgt : '0;
          load_pend = !bus.imem_ready;
          nstate = bus.imem_ready ? SEQ_RUN : SEQ_WAIT;
        end else if (win == WIN_NONE && bus.imem_ready) sel = PCS_INC;
      end
      SEQ_WAIT: begin
        tgt = pend_tgt;
        sel = bus.imem_ready ? (pend_vec ? PCS_VEC : PCS_TGT) : PCS_HOLD;
        fl_ifid = bus.imem_ready;
        nstate = bus.imem_ready ? SEQ_RUN : SEQ_WAIT;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEQ_RUN;
      pend_tgt <= '0;
      pend_vec <= 1'b0;
      epc <= '0;
      in_handler <= 1'b0;
    end else begin
      state <= nstate;
      if (load_pend) begin
        pend_tgt <= arb_tgt;
        pend_vec <= vec;
      end
      if (take_exc) epc <= bus.siic_pc + AW'(2);
      if (take_exc) in_handler <= 1'b1;
      else if (take_rti) in_handler <= 1'b0;
    end
  end
  // reset must present HOLD immediately, even though RUN would otherwise select INC
  assign bus.pc_sel = rst_n ? sel : PCS_HOLD;
  assign bus.pc_tgt = rst_n ? tgt : '0;
  assign bus.flush_ifid = rst_n & fl_ifid;
  assign bus.flush_idex = rst_n & fl_idex;
  assign bus.epc = epc;
  assign bus.in_handler = in_handler;
  assign bus.halted = state == SEQ_HALT;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of PC select arbitration, redirect wait, exceptions and halt
module tb_pc_sequencer;
  import cpu_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  pc_sequencer_if #(.AW(16)) bus ();
  pc_sequencer #(.AW(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic drive(input logic s, h, r, rd, st, rdy, input logic [15:0] rt, sp);
    @(negedge clk);
    bus.siic_req = s;
    bus.halt_req = h;
    bus.rti_req = r;
    bus.redir_req = rd;
    bus.hazard_stall = st;
    bus.imem_ready = rdy;
    bus.redir_tgt = rt;
    bus.siic_pc = sp;
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.siic_req = 0; bus.halt_req = 0; bus.rti_req = 0; bus.redir_req = 0;
    bus.hazard_stall = 0; bus.imem_ready = 1; bus.redir_tgt = '0; bus.siic_pc = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.siic_req = 0; bus.halt_req = 0; bus.rti_req = 0; bus.redir_req = 0;
    bus.hazard_stall = 0; bus.imem_ready = 1; bus.redir_tgt = '0; bus.siic_pc = '0;
    #1;
    checks++;
    if (bus.pc_sel !== PCS_HOLD || bus.pc_tgt !== 16'h0 || bus.flush_ifid !== 1'b0 || bus.flush_idex !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: sel=%b tgt=%h fl=%b%b want sel=01 tgt=0000 fl=00", bus.pc_sel, bus.pc_tgt, bus.flush_ifid, bus.flush_idex);
    end
    checks++;
    if (bus.epc !== 16'h0 || bus.in_handler !== 1'b0 || bus.halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: epc=%h ih=%b halted=%b want 0000 0 0", bus.epc, bus.in_handler, bus.halted);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_idle();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
      checks++;
      if (bus.pc_sel !== PCS_INC || bus.flush_ifid !== 1'b0 || bus.flush_idex !== 1'b0 || bus.pc_tgt !== 16'h0) begin
        errors++;
        $display("FAIL idle_%0d: sel=%b fl=%b%b tgt=%h want sel=00 fl=00 tgt=0000", i, bus.pc_sel, bus.flush_ifid, bus.flush_idex, bus.pc_tgt);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
    checks++;
    if (bus.pc_sel !== PCS_HOLD) begin
      errors++;
      $display("FAIL idle_not_ready: sel=%b want 01", bus.pc_sel);
    end
  endtask
  task automatic test_redirect();
    drive(0, 0, 0, 1, 0, 1, 16'h0040, 16'h0);
    checks++;
    if (bus.pc_sel !== PCS_TGT || bus.pc_tgt !== 16'h0040 || bus.flush_ifid !== 1'b1 || bus.flush_idex !== 1'b1) begin
      errors++;
      $display("FAIL redirect: sel=%b tgt=%h fl=%b%b want sel=10 tgt=0040 fl=11", bus.pc_sel, bus.pc_tgt, bus.flush_ifid, bus.flush_idex);
    end
    drive(0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
    checks++;
    if (bus.pc_sel !== PCS_INC || bus.flush_ifid !== 1'b0) begin
      errors++;
      $display("FAIL redirect_after: sel=%b fl_ifid=%b want sel=00 fl_ifid=0", bus.pc_sel, bus.flush_ifid);
    end
  endtask
  task automatic test_wait_imem();
    drive(0, 0, 0, 1, 0, 0, 16'h0080, 16'h0);
    checks++;
    if (bus.pc_sel !== PCS_HOLD || bus.pc_tgt !== 16'h0 || bus.flush_ifid !== 1'b1 || bus.flush_idex !== 1'b1) begin
      errors++;
      $display("FAIL wait_req: sel=%b tgt=%h fl=%b%b want sel=01 tgt=0000 fl=11", bus.pc_sel, bus.pc_tgt, bus.flush_ifid, bus.flush_idex);
    end
    drive(1, 0, 0, 0, 0, 0, 16'h0, 16'h0200);
    checks++;
    if (bus.pc_sel !== PCS_HOLD || bus.pc_tgt !== 16'h0080 || bus.flush_ifid !== 1'b0 || bus.flush_idex !== 1'b0) begin
      errors++;
      $display("FAIL wait_siic_ignored: sel=%b tgt=%h fl=%b%b want sel=01 tgt=0080 fl=00", bus.pc_sel, bus.pc_tgt, bus.flush_ifid, bus.flush_idex);
    end
    drive(0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
    checks++;
    if (bus.pc_sel !== PCS_HOLD || bus.epc !== 16'h0 || bus.in_handler !== 1'b0) begin
      errors++;
      $display("FAIL wait_hold3: sel=%b epc=%h ih=%b want sel=01 epc=0000 ih=0", bus.pc_sel, bus.epc, bus.in_handler);
    end
    drive(0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
    checks++;
    if (bus.pc_sel !== PCS_TGT || bus.pc_tgt !== 16'h0080 || bus.flush_ifid !== 1'b1 || bus.flush_idex !== 1'b0) begin
      errors++;
      $display("FAIL wait_release: sel=%b tgt=%h fl=%b%b want sel=10 tgt=0080 fl=10", bus.pc_sel, bus.pc_tgt, bus.flush_ifid, bus.flush_idex);
    end
    drive(0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
    checks++;
    if (bus.pc_sel !== PCS_INC) begin
      errors++;
      $display("FAIL wait_back_to_run: sel=%b want 00", bus.pc_sel);
    end
  endtask
  task automatic test_exception();
    drive(1, 0, 0, 0, 0, 1, 16'h0, 16'h0100);
    checks++;
    if (bus.pc_sel !== PCS_VEC || bus.pc_tgt !== 16'h0002 || bus.flush_ifid !== 1'b1 || bus.flush_idex !== 1'b1) begin
      errors++;
      $display("FAIL siic: sel=%b tgt=%h fl=%b%b want sel=11 tgt=0002 fl=11", bus.pc_sel, bus.pc_tgt, bus.flush_ifid, bus.flush_idex);
    end
    drive(0, 0, 1, 0, 0, 1, 16'h0, 16'h0);
    checks++;
    if (bus.epc !== 16'h0102 || bus.in_handler !== 1'b1) begin
      errors++;
      $display("FAIL siic_epc: epc=%h ih=%b want 0102 1", bus.epc, bus.in_handler);
    end
    checks++;
    if (bus.pc_sel !== PCS_TGT || bus.pc_tgt !== 16'h0102) begin
      errors++;
      $display("FAIL rti: sel=%b tgt=%h want sel=10 tgt=0102", bus.pc_sel, bus.pc_tgt);
    end
    drive(1, 0, 0, 0, 0, 1, 16'h0, 16'hFFFE);
    checks++;
    if (bus.in_handler !== 1'b0) begin
      errors++;
      $display("FAIL rti_clear: ih=%b want 0", bus.in_handler);
    end
    drive(0, 0, 1, 0, 0, 1, 16'h0, 16'h0);
    checks++;
    if (bus.epc !== 16'h0000 || bus.in_handler !== 1'b1 || bus.pc_tgt !== 16'h0000 || bus.pc_sel !== PCS_TGT) begin
      errors++;
      $display("FAIL siic_wrap: epc=%h ih=%b sel=%b tgt=%h want epc=0000 ih=1 sel=10 tgt=0000", bus.epc, bus.in_handler, bus.pc_sel, bus.pc_tgt);
    end
    drive(0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
  endtask
  task automatic test_priority();
    drive(1, 1, 0, 1, 0, 1, 16'h0044, 16'h0300);
    checks++;
    if (bus.pc_sel !== PCS_VEC || bus.pc_tgt !== 16'h0002) begin
      errors++;
      $display("FAIL prio_siic: sel=%b tgt=%h want sel=11 tgt=0002", bus.pc_sel, bus.pc_tgt);
    end
    drive(0, 0, 1, 0, 0, 1, 16'h0, 16'h0);
    checks++;
    if (bus.epc !== 16'h0302 || bus.in_handler !== 1'b1 || bus.halted !== 1'b0) begin
      errors++;
      $display("FAIL prio_siic_state: epc=%h ih=%b halted=%b want 0302 1 0", bus.epc, bus.in_handler, bus.halted);
    end
    drive(0, 0, 0, 1, 1, 1, 16'h0050, 16'h0);
    checks++;
    if (bus.pc_sel !== PCS_TGT || bus.pc_tgt !== 16'h0050 || bus.flush_idex !== 1'b1) begin
      errors++;
      $display("FAIL prio_redir_stall: sel=%b tgt=%h fl_idex=%b want sel=10 tgt=0050 fl_idex=1", bus.pc_sel, bus.pc_tgt, bus.flush_idex);
    end
    drive(0, 0, 0, 0, 1, 1, 16'h0, 16'h0);
    checks++;
    if (bus.pc_sel !== PCS_HOLD || bus.pc_tgt !== 16'h0 || bus.flush_ifid !== 1'b0 || bus.flush_idex !== 1'b0) begin
      errors++;
      $display("FAIL prio_stall: sel=%b tgt=%h fl=%b%b want sel=01 tgt=0000 fl=00", bus.pc_sel, bus.pc_tgt, bus.flush_ifid, bus.flush_idex);
    end
  endtask
  task automatic test_halt();
    drive(0, 1, 0, 1, 0, 1, 16'h0070, 16'h0);
    checks++;
    if (bus.pc_sel !== PCS_HOLD || bus.flush_ifid !== 1'b1 || bus.flush_idex !== 1'b1) begin
      errors++;
      $display("FAIL halt_req: sel=%b fl=%b%b want sel=01 fl=11", bus.pc_sel, bus.flush_ifid, bus.flush_idex);
    end
    drive(0, 0, 0, 1, 0, 1, 16'h0070, 16'h0);
    checks++;
    if (bus.halted !== 1'b1 || bus.pc_sel !== PCS_HOLD || bus.pc_tgt !== 16'h0 || bus.flush_ifid !== 1'b0) begin
      errors++;
      $display("FAIL halted_redir: halted=%b sel=%b tgt=%h fl_ifid=%b want 1 01 0000 0", bus.halted, bus.pc_sel, bus.pc_tgt, bus.flush_ifid);
    end
    do_reset();
    #1;
    checks++;
    if (bus.halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset: halted=%b want 0", bus.halted);
    end
  endtask
  task automatic test_nested();
    drive(1, 0, 0, 0, 0, 1, 16'h0, 16'h0400);
    drive(1, 0, 0, 0, 0, 1, 16'h0, 16'h0500);
    checks++;
    if (bus.pc_sel !== PCS_HOLD || bus.in_handler !== 1'b1) begin
      errors++;
      $display("FAIL nested_req: sel=%b ih=%b want sel=01 ih=1", bus.pc_sel, bus.in_handler);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, i[0], !i[0], 0, 1, 16'h0090, 16'h0);
      checks++;
      if (bus.halted !== 1'b1 || bus.pc_sel !== PCS_HOLD || bus.epc !== 16'h0402 || bus.flush_idex !== 1'b0) begin
        errors++;
        $display("FAIL nested_halted_%0d: halted=%b sel=%b epc=%h fl_idex=%b want 1 01 0402 0", i, bus.halted, bus.pc_sel, bus.epc, bus.flush_idex);
      end
    end
    do_reset();
    #1;
    checks++;
    if (bus.halted !== 1'b0 || bus.epc !== 16'h0 || bus.in_handler !== 1'b0) begin
      errors++;
      $display("FAIL nested_reset: halted=%b epc=%h ih=%b want 0 0000 0", bus.halted, bus.epc, bus.in_handler);
    end
  endtask
  task automatic test_reset_in_wait();
    drive(0, 0, 0, 1, 0, 0, 16'h0060, 16'h0);
    drive(0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
    checks++;
    if (bus.pc_tgt !== 16'h0060 || bus.pc_sel !== PCS_HOLD) begin
      errors++;
      $display("FAIL rstwait_pending: sel=%b tgt=%h want sel=01 tgt=0060", bus.pc_sel, bus.pc_tgt);
    end
    bus.imem_ready = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.pc_sel !== PCS_HOLD || bus.pc_tgt !== 16'h0 || bus.flush_ifid !== 1'b0) begin
      errors++;
      $display("FAIL rstwait_async: sel=%b tgt=%h fl_ifid=%b want sel=01 tgt=0000 fl_ifid=0", bus.pc_sel, bus.pc_tgt, bus.flush_ifid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
    checks++;
    if (bus.pc_sel !== PCS_INC || bus.pc_tgt !== 16'h0) begin
      errors++;
      $display("FAIL rstwait_dropped: sel=%b tgt=%h want sel=00 tgt=0000", bus.pc_sel, bus.pc_tgt);
    end
  endtask
  initial begin
    test_reset();
    test_idle();
    test_redirect();
    test_wait_imem();
    test_exception();
    test_priority();
    test_halt();
    test_nested();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
